// File: rtl/chunked_addsub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding and
// chunking helpers used at elaboration time.
package chunked_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A legal configuration splits the operand into whole, non-empty slices.
    function automatic bit chunking_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunked_addsub_ripple_adder_n.sv
// Purely combinational N-bit ripple-carry adder built from fulladder cells.
module ripple_adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fulladder u_fa (
            .a    (in_a[i]),
            .b    (in_b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[N];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell; the building block of the ripple slice.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-wide ripple slice is reused over
// WIDTH/CHUNK cycles, with valid/ready handshakes on both sides.
module chunked_addsub
    import chunked_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = $clog2(NCHUNK) + 1;

    if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_chunking
        $error("chunked_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_nx;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic [CHUNK-1:0] a_chunk, b_chunk, slice_sum;
    logic             slice_cout;
    logic             last_chunk;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q;

    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    // State register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create order-dependent races.
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake outputs
    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves
        // a signal unassigned and no latch is inferred.
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last_chunk) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Chunk mux: select slice idx of both operands
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    ripple_adder_n #(.N(CHUNK)) u_slice (
        .in_a (a_chunk),
        .in_b (b_chunk),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Chunk demux: the working accumulator with slice idx replaced
    always_comb begin
        acc_nx = acc_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) acc_nx[i*CHUNK +: CHUNK] = slice_sum;
        end
    end

    // Operand and working registers
    always_ff @(posedge clk) begin
        // NOTE: pure datapath registers are left unreset; each is loaded on accept
        // or written chunk by chunk before anything downstream reads it.
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_q     <= in_a;
                    b_q     <= sub ? ~in_b : in_b;
                    carry_q <= cin ^ sub;
                    idx_q   <= '0;
                end
            end
            RUN: begin
                acc_q   <= acc_nx;
                carry_q <= slice_cout;
                idx_q   <= idx_q + IDXW'(1);
            end
            default: ;
        endcase
    end

    // Published result: updated only as the last chunk completes, so sum and
    // flags hold through backpressure and idle until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == RUN && last_chunk) begin
            sum_q  <= acc_nx;
            cout_q <= slice_cout;
            ovf_q  <= (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (acc_nx[WIDTH-1] ^ a_q[WIDTH-1]);
            zero_q <= (acc_nx == '0);
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed bench for chunked_addsub in three configurations (16/4, 8/8, 32/4)
// plus reference-model checked random operations.
module tb_chunked_addsub;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 16/4 instance
    logic        v16, ir16, ov16, or16, s16, c16, co16, of16, z16;
    logic [15:0] a16, b16, sum16;
    // 8/8 instance
    logic        v8, ir8, ov8, or8, s8, c8, co8, of8, z8;
    logic [7:0]  a8, b8, sum8;
    // 32/4 instance
    logic        v32, ir32, ov32, or32, s32, c32, co32, of32, z32;
    logic [31:0] a32, b32, sum32;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .cin(c16), .sub(s16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
        .cout(co16), .ovf(of16), .zero(z16)
    );

    chunked_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .cin(c8), .sub(s8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
        .cout(co8), .ovf(of8), .zero(z8)
    );

    chunked_addsub #(.WIDTH(32), .CHUNK(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .in_a(a32), .in_b(b32),
        .cin(c32), .sub(s32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .cout(co32), .ovf(of32), .zero(z32)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_in(input int w, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s);
        case (w)
            8:  begin v8  = v; a8  = a[7:0];  b8  = b[7:0];  c8  = c; s8  = s; end
            16: begin v16 = v; a16 = a[15:0]; b16 = b[15:0]; c16 = c; s16 = s; end
            default: begin v32 = v; a32 = a; b32 = b; c32 = c; s32 = s; end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic r);
        case (w)
            8:  or8  = r;
            16: or16 = r;
            default: or32 = r;
        endcase
    endtask

    function automatic logic [31:0] get_sum(input int w);
        case (w)
            8:  return {24'd0, sum8};
            16: return {16'd0, sum16};
            default: return sum32;
        endcase
    endfunction

    // {in_ready, out_valid, cout, ovf, zero}
    function automatic logic [4:0] get_ctl(input int w);
        case (w)
            8:  return {ir8, ov8, co8, of8, z8};
            16: return {ir16, ov16, co16, of16, z16};
            default: return {ir32, ov32, co32, of32, z32};
        endcase
    endfunction

    // Reference: plain wide arithmetic, overflow from operand/result signs
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s, output logic [31:0] e_sum,
                         output logic e_cout, output logic e_ovf, output logic e_zero);
        logic [63:0] mask, aa, bb, full;
        logic sa, sb, ss;
        mask = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & mask;
        bb = {32'd0, b} & mask;
        if (s) full = aa + (~bb & mask) + (c ? 64'd0 : 64'd1);
        else   full = aa + bb + {63'd0, c};
        e_sum  = 32'(full & mask);
        e_cout = full[w];
        sa = aa[w-1];
        sb = bb[w-1];
        ss = full[w-1];
        e_ovf  = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        e_zero = ((full & mask) == 64'd0);
    endtask

    // One full transaction: accept, measure latency, check result, drain.
    task automatic op(input string tag, input int w, input int chunk,
                      input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                      input logic [31:0] e_sum, input logic e_cout, input logic e_ovf, input logic e_zero);
        int lat;
        logic [4:0] ctl;
        lat = 0;
        check({tag, ".ready_before"}, 64'(get_ctl(w) >> 4), 64'd1);
        set_in(w, 1'b1, a, b, c, s);
        @(posedge clk); #1;
        set_in(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        check({tag, ".busy"}, 64'(get_ctl(w) >> 3), 64'd0);
        for (int k = 1; k <= 64 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (get_ctl(w) & 5'b01000) lat = k;
        end
        check({tag, ".latency"}, 64'(lat), 64'(w / chunk));
        ctl = get_ctl(w);
        check({tag, ".sum"}, 64'(get_sum(w)), 64'(e_sum));
        check({tag, ".flags"}, 64'(ctl[2:0]), 64'({e_cout, e_ovf, e_zero}));
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
        check({tag, ".drained"}, 64'(get_ctl(w) >> 3), 64'b10);
        check({tag, ".sum_kept"}, 64'(get_sum(w)), 64'(e_sum));
    endtask

    task automatic rand_ops(input int w, input int chunk, input int n);
        logic [31:0] a, b, e_sum;
        logic c, s, e_cout, e_ovf, e_zero;
        for (int i = 0; i < n; i++) begin
            a = $urandom();
            b = $urandom();
            if (i % 7 == 0) a = '1;
            if (i % 11 == 0) b = 32'd0;
            c = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            model(w, a, b, c, s, e_sum, e_cout, e_ovf, e_zero);
            op($sformatf("rnd%0d_%0d", w, i), w, chunk, a, b, c, s, e_sum, e_cout, e_ovf, e_zero);
        end
    endtask

    initial begin
        logic any_valid;
        int   waited;
        logic [4:0] ctl;

        rst = 1'b1;
        set_in(8, 1'b0, 0, 0, 0, 0);
        set_in(16, 1'b0, 0, 0, 0, 0);
        set_in(32, 1'b0, 0, 0, 0, 0);
        or8 = 1'b0; or16 = 1'b0; or32 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.ctl16", 64'(get_ctl(16)), 64'b10000);
        check("reset.sum16", 64'(sum16), 64'd0);
        check("reset.ctl32", 64'(get_ctl(32)), 64'b10000);

        // Directed 16/4 vectors
        op("add_5555", 16, 4, 32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 1'b0, 1'b0, 1'b0);
        op("add_wrap", 16, 4, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0, 1'b1);
        op("add_ovf",  16, 4, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1, 1'b0);
        op("add_cin",  16, 4, 32'h00FF, 32'h0000, 1'b1, 1'b0, 32'h0100, 1'b0, 1'b0, 1'b0);
        op("sub_neg",  16, 4, 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0, 1'b0);
        op("sub_ovf",  16, 4, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1, 1'b0);
        op("sub_bin",  16, 4, 32'h0005, 32'h0005, 1'b1, 1'b1, 32'hFFFF, 1'b0, 1'b0, 1'b0);
        op("sub_zero", 16, 4, 32'h1234, 32'h1234, 1'b0, 1'b1, 32'h0000, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of RUN discards the operation
        set_in(16, 1'b1, 32'hAAAA, 32'h5555, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(16, 1'b0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_reset.ctl", 64'(get_ctl(16)), 64'b10000);
        check("midrun_reset.sum", 64'(sum16), 64'd0);
        any_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            any_valid = any_valid | ov16;
        end
        check("midrun_reset.no_stale", 64'(any_valid), 64'd0);

        // Backpressure: result held, new operands ignored until drained
        set_in(16, 1'b1, 32'h1234, 32'h4321, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_in(16, 1'b1, 32'h1111, 32'h1111, 1'b0, 1'b0);
        waited = 0;
        while (!ov16 && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        check("bp.latency", 64'(waited), 64'd4);
        for (int k = 0; k < 5; k++) begin
            ctl = get_ctl(16);
            check($sformatf("bp.hold_sum%0d", k), 64'(sum16), 64'h5555);
            check($sformatf("bp.hold_ctl%0d", k), 64'(ctl), 64'b01000);
            @(posedge clk); #1;
        end
        or16 = 1'b1;
        @(posedge clk); #1;
        check("bp.released", 64'(get_ctl(16) >> 3), 64'b10);
        check("bp.sum_after_release", 64'(sum16), 64'h5555);
        // out_ready stays high through the next operation: no effect outside DONE
        @(posedge clk); #1;
        set_in(16, 1'b0, 0, 0, 0, 0);
        check("bp.new_accept", 64'(get_ctl(16) >> 3), 64'b00);
        waited = 0;
        while (!ov16 && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        check("bp.new_latency", 64'(waited), 64'd4);
        check("bp.new_sum", 64'(sum16), 64'h2222);
        @(posedge clk); #1;
        or16 = 1'b0;
        check("bp.new_drained", 64'(get_ctl(16) >> 3), 64'b10);

        // Single-chunk configuration (one RUN cycle)
        op("w8_ovf_wrap", 8, 8, 32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1);
        op("w8_sub",      8, 8, 32'h10, 32'h20, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0, 1'b0);
        // 32-bit, eight chunks
        op("w32_wrap", 32, 4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        op("w32_cin",  32, 4, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0, 1'b0, 1'b0);

        rand_ops(8, 8, 1000);
        rand_ops(32, 4, 1000);
        rand_ops(16, 4, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
Parametrised multi-cycle adder/subtractor. Processes a WIDTH-bit operand pair CHUNK bits per clock through one registered ripple-carry slice, so wide operands cost area for one slice only. Operands enter and results leave through valid/ready handshakes. Produces carry, signed overflow and zero flags. It is the wide-operand arithmetic unit for the ALU datapath.

Parameters:
- WIDTH, 16: operand and result width. Must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4: bits added per cycle, which is the width of the ripple slice.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  unit can accept an operation.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- cin  in  1  carry-in for add; borrow-in for sub.
- sub  in  1  0 selects a+b+cin; 1 selects a-b-cin.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB; for sub, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum is all zeros.

Behaviour:
- Reset (one cycle of rst=1):
  - state goes to IDLE; in_ready=1, out_valid=0.
  - sum, cout, ovf, zero all go to 0.
  - Any operation in flight is discarded. rst overrides all other inputs in that cycle.
- NCHUNK = WIDTH/CHUNK.
- Internal registers: A, B' (WIDTH), carry (1), idx (clog2(NCHUNK)+1 bits).
- IDLE:
  - in_ready=1.
  - On in_valid: A<=in_a; B'<=sub ? ~in_b : in_b; carry<=cin^sub; idx<=0; go to RUN.
  - Input values are only sampled in the accept cycle.
- RUN:
  - in_ready=0.
  - Each cycle, chunk idx of A, chunk idx of B' and carry feed the slice.
  - The slice result is written to sum chunk idx, carry<=slice cout, idx<=idx+1.
  - Chunk 0 is the LSB chunk.
  - After the chunk with idx=NCHUNK-1, go to DONE.
- DONE:
  - out_valid=1; cout=final carry.
  - ovf=(A[MSB]~^B'[MSB]) & (sum[MSB]^A[MSB]); zero=(sum==0).
  - Hold sum and all flags stable while out_valid=1 and out_ready=0.
  - in_ready=0; in_valid is ignored.
  - On out_ready: out_valid<=0, go to IDLE. Outputs keep their last values until the next DONE.
- Latency: operation accepted at edge T gives out_valid=1 after edge T+NCHUNK. For the defaults that is 4 cycles.
- Throughput: at best one operation per NCHUNK+2 cycles. There is no overlap of accept and result.
- Width rules:
  - Results are modulo 2^WIDTH.
  - sub with cin=0 computes a + ~b + 1.
  - sub with cin=1 computes a + ~b (borrow in).
- Boundary cases:
  - 0xFFFF+1 wraps to 0 with cout=1.
  - NCHUNK=1 (CHUNK=WIDTH) must work with one RUN cycle.
  - in_valid held high across DONE does not start a second operation until IDLE.
  - out_ready high while not in DONE has no effect.

Decomposition:
- Shared package/header holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - the NCHUNK derivation.
  - a WIDTH%CHUNK==0 elaboration check.
- Sub-module ripple_adder_n (parameter N = CHUNK):
  - purely combinational N-bit ripple chain built from the existing fulladder cell.
  - ports in_a, in_b, cin, sum, cout.
- Top level holds the FSM, operand/carry registers, chunk mux/demux and flag logic.

Test Plan:
1. Reset: assert rst for 2 cycles mid-RUN of any operation -> next cycle in_ready=1, out_valid=0, sum=0, all flags 0; no stale result ever appears.
2. Add 0x1234+0x4321, cin=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x5555, cout=0, ovf=0, zero=0.
3. Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0. Add 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
4. Sub 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1. Sub 0x0005-0x0005, cin=1 -> sum=0xFFFF, cout=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> sum and flags unchanged, in_ready=0, no new accept. Then raise out_ready -> IDLE next cycle, new operand accepted.
6. Parameter sweep: WIDTH=8/CHUNK=8 and WIDTH=32/CHUNK=4, 1000 random operations each vs a reference model -> results and flags match; latency is 1 and 8 cycles respectively.
